// File: rtl/qci_pkg.sv
// Shared definitions for the quartic code inverter: the FSM state type,
// the datapath widths and the forward map F(x) = ((x*x) mod 32)^2.
package qci_pkg;

    localparam int CODE_W   = 10;
    localparam int X_W      = 4;
    localparam int NUM_CAND = 16;
    localparam int SQ_MOD_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Forward map: square in 8 bits, keep the low 5 bits, square again in 10 bits.
    function automatic logic [CODE_W-1:0] fwd_map(input logic [X_W-1:0] x);
        logic [2*X_W-1:0]    sq;
        logic [SQ_MOD_W-1:0] s;
        sq = {{X_W{1'b0}}, x} * {{X_W{1'b0}}, x};
        s  = sq[SQ_MOD_W-1:0];
        return {{SQ_MOD_W{1'b0}}, s} * {{SQ_MOD_W{1'b0}}, s};
    endfunction

endpackage

// File: rtl/qci_lane.sv
// One search lane: flags whether candidate x maps onto the requested code y.
module qci_lane
    import qci_pkg::*;
(
    input  logic [X_W-1:0]    x,
    input  logic [CODE_W-1:0] y,
    output logic              match
);

    assign match = (fwd_map(x) == y);

endmodule

// File: rtl/quartic_code_inverter.sv
// Quartic code inverter: finds every x in 0..15 with F(x) == in_code by
// scanning LANES candidates per cycle, then reports the smallest match,
// the match count and a found flag.
// Optional feature macro: QCI_MATCH_MASK_EN adds out_mask[15:0] (bit x set iff F(x) == y).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The producer holds in_valid/in_code until in_ready; the block holds
// out_valid and all result outputs stable until out_ready.
module quartic_code_inverter
    import qci_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_found,
    output logic [X_W-1:0]      out_value,
    output logic [X_W:0]        out_count,
`ifdef QCI_MATCH_MASK_EN
    output logic [NUM_CAND-1:0] out_mask,
`endif
    output state_t              dbg_state
);

    localparam int LAST_CAND = NUM_CAND - LANES;

    state_t              state;
    state_t              state_nxt;
    logic [X_W-1:0]      cand;
    logic [CODE_W-1:0]   code_q;
    logic [X_W-1:0]      lane_x     [LANES];
    logic                lane_match [LANES];
    logic                grp_any;
    logic [X_W-1:0]      grp_first;
    logic [X_W:0]        grp_cnt;
    logic                last_grp;
`ifdef QCI_MATCH_MASK_EN
    logic [NUM_CAND-1:0] grp_mask;
`endif

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;
    assign last_grp  = (cand == X_W'(LAST_CAND));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_x[i] = cand + X_W'(i);
        qci_lane u_lane (
            .x     (lane_x[i]),
            .y     (code_q),
            .match (lane_match[i])
        );
    end

    // Reduce the current group: lowest matching lane wins, count all matches.
    always_comb begin
        grp_any   = 1'b0;
        grp_first = '0;
        grp_cnt   = '0;
`ifdef QCI_MATCH_MASK_EN
        grp_mask  = '0;
`endif
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_match[i]) begin
                grp_any   = 1'b1;
                grp_first = lane_x[i];
                grp_cnt   = grp_cnt + 5'd1;
`ifdef QCI_MATCH_MASK_EN
                grp_mask[lane_x[i]] = 1'b1;
`endif
            end
        end
    end

    // Next-state logic: accept in IDLE, scan in SEARCH, hold in DONE until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)              state_nxt = SEARCH;
            SEARCH:  if (last_grp)              state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: latch the code, accumulate group results, raise out_valid one cycle into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand      <= '0;
            code_q    <= '0;
            out_valid <= 1'b0;
            out_found <= 1'b0;
            out_value <= '0;
            out_count <= '0;
`ifdef QCI_MATCH_MASK_EN
            out_mask  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        code_q    <= in_code;
                        cand      <= '0;
                        out_found <= 1'b0;
                        out_value <= '0;
                        out_count <= '0;
`ifdef QCI_MATCH_MASK_EN
                        out_mask  <= '0;
`endif
                    end
                end
                SEARCH: begin
                    cand      <= cand + X_W'(LANES);
                    out_count <= out_count + grp_cnt;
                    if (grp_any && !out_found) begin
                        out_found <= 1'b1;
                        out_value <= grp_first;
                    end
`ifdef QCI_MATCH_MASK_EN
                    out_mask  <= out_mask | grp_mask;
`endif
                end
                DONE: begin
                    out_valid <= !(out_valid && out_ready);
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quartic_code_inverter.sv
// Bench for quartic_code_inverter: three instances (LANES = 1, 4, 16) run in
// lockstep on the same requests; a reference model fills an expected queue and
// a monitor compares every result handshake, latency and hold stability.
`timescale 1ns/1ps
module tb_quartic_code_inverter;
    import qci_pkg::*;

    localparam int W = 26; // {found, value[3:0], count[4:0], mask[15:0]}
`ifdef QCI_MATCH_MASK_EN
    localparam logic [15:0] MASK_KEEP = 16'hFFFF;
`else
    localparam logic [15:0] MASK_KEEP = 16'h0000;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [9:0]  in_code   = '0;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  of;
    logic [3:0]  ovl  [3];
    logic [4:0]  ocnt [3];
    state_t      dbg  [3];
`ifdef QCI_MATCH_MASK_EN
    logic [15:0] omask [3];
`endif

    quartic_code_inverter #(.LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_code(in_code),
        .out_valid(ov[0]), .out_ready(out_ready), .out_found(of[0]), .out_value(ovl[0]),
        .out_count(ocnt[0]),
`ifdef QCI_MATCH_MASK_EN
        .out_mask(omask[0]),
`endif
        .dbg_state(dbg[0]));

    quartic_code_inverter #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_code(in_code),
        .out_valid(ov[1]), .out_ready(out_ready), .out_found(of[1]), .out_value(ovl[1]),
        .out_count(ocnt[1]),
`ifdef QCI_MATCH_MASK_EN
        .out_mask(omask[1]),
`endif
        .dbg_state(dbg[1]));

    quartic_code_inverter #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_code(in_code),
        .out_valid(ov[2]), .out_ready(out_ready), .out_found(of[2]), .out_value(ovl[2]),
        .out_count(ocnt[2]),
`ifdef QCI_MATCH_MASK_EN
        .out_mask(omask[2]),
`endif
        .dbg_state(dbg[2]));

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           rd_idx [3];
    bit           seen   [3];
    logic [W-1:0] held   [3];
    int           acc_cyc  = 0;
    int           n_checks = 0;
    int           n_pass   = 0;
    bit           rand_rdy = 1'b0;

    function automatic int lanes_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 16;
    endfunction

    // Reference: brute force over all 16 candidates with plain integer arithmetic.
    function automatic logic [W-1:0] model(input int y);
        int          cnt;
        int          val;
        int          s;
        logic [15:0] m;
        cnt = 0; val = 0; m = '0;
        for (int x = 0; x < 16; x++) begin
            s = (x * x) % 32;
            if (s * s == y) begin
                if (cnt == 0) val = x;
                cnt++;
                m[x] = 1'b1;
            end
        end
        return {cnt != 0, 4'(val), 5'(cnt), m & MASK_KEEP};
    endfunction

    function automatic logic [W-1:0] obs(input int k);
        logic [15:0] m;
`ifdef QCI_MATCH_MASK_EN
        m = omask[k];
`else
        m = 16'h0;
`endif
        return {of[k], ovl[k], ocnt[k], m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (ov[k]) begin
                    if (!seen[k]) begin
                        seen[k] = 1'b1;
                        held[k] = obs(k);
                        check($sformatf("latency_l%0d", lanes_of(k)), 32'(cyc - acc_cyc),
                              32'(16 / lanes_of(k) + 1));
                    end else begin
                        check($sformatf("hold_l%0d", lanes_of(k)), 32'(obs(k)), 32'(held[k]));
                    end
                    check($sformatf("busy_ready_l%0d", lanes_of(k)), 32'(ir[k]), 32'd0);
                    if (out_ready) begin
                        if (rd_idx[k] < exp_q.size())
                            check($sformatf("result_l%0d", lanes_of(k)), 32'(obs(k)),
                                  32'(exp_q[rd_idx[k]]));
                        else begin
                            n_checks++;
                            $display("FAIL unexpected_l%0d: got %h expected none", lanes_of(k), obs(k));
                        end
                        rd_idx[k]++;
                        seen[k] = 1'b0;
                    end
                end
            end
            while (exp_q.size() > 0 && rd_idx[0] > 0 && rd_idx[1] > 0 && rd_idx[2] > 0) begin
                void'(exp_q.pop_front());
                for (int k = 0; k < 3; k++) rd_idx[k]--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int t;
        t = 0;
        while (ir != 3'b111 && t < 300) begin
            @(negedge clk);
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            t++;
        end
        if (ir != 3'b111) fail_now("wait_idle");
    endtask

    task automatic send(input logic [9:0] code);
        wait_idle();
        in_valid = 1'b1;
        in_code  = code;
        @(posedge clk);
        exp_q.push_back(model(int'(code)));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_code  = 10'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || ir != 3'b111) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || ir != 3'b111) fail_now("drain");
    endtask

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_in_ready_l%0d", tag, lanes_of(k)), 32'(ir[k]), 32'd1);
            check($sformatf("%s_out_valid_l%0d", tag, lanes_of(k)), 32'(ov[k]), 32'd0);
            check($sformatf("%s_outputs_l%0d", tag, lanes_of(k)), 32'(obs(k)), 32'd0);
            check($sformatf("%s_state_l%0d", tag, lanes_of(k)), 32'(dbg[k]), 32'(IDLE));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int x;
        logic [9:0] y;
        for (int k = 0; k < 3; k++) begin rd_idx[k] = 0; seen[k] = 1'b0; held[k] = '0; end

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed codes, consumer always ready (out_ready early has no effect).
        out_ready = 1'b1;
        send(10'd16);
        send(10'd625);
        send(10'd0);
        send(10'd3);
        send(10'd1000);
        send(10'd961);
        send(10'd962);
        drain();

        // Consumer stalls; a second request while busy must be ignored.
        out_ready = 1'b0;
        send(10'd1);
        in_valid = 1'b1;
        in_code  = 10'd16;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(ir), 32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        drain();

        // Reset in the middle of the search drops the request.
        out_ready = 1'b0;
        send(10'd81);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_values("midrst");
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin rd_idx[k] = 0; seen[k] = 1'b0; end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send(10'd289);
        drain();

        // Randomized codes with a randomly stalling consumer.
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                x = $urandom_range(0, 15);
                y = 10'(((x * x) % 32) * ((x * x) % 32));
            end else begin
                y = 10'($urandom_range(0, 1023));
            end
            send(y);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

endmodule
